comb_seq_ctrl: RTL

// Shares one Comb ALU instance (8-bit add/sub/and/or against a selectable constant) between NREQ requesters.

---
 rtl/comb_ctrl_pkg.sv | 31 +++
 rtl/Comb.sv | 34 +++
 rtl/comb_seq_ctrl_arb.sv | 26 ++
 rtl/comb_seq_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/comb_ctrl_pkg.sv
// Shared types and constants for the Comb sequencing controller.
// The helper maps a constant select to its odd constant K (1, 3, 5, 7).
package comb_ctrl_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        CSEL_1 = 2'd0,
        CSEL_3 = 2'd1,
        CSEL_5 = 2'd2,
        CSEL_7 = 2'd3
    } csel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] csel_to_k(input csel_e c);
        return {{(DATA_W-3){1'b0}}, c, 1'b1};
    endfunction

endpackage

// File: rtl/Comb.sv
// Comb ALU: 8-bit add/sub/and/or of the input against a selectable constant.
// AND/OR use the negated constant (-K mod 256); the carry-in is tied low.
module Comb
    import comb_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] MyInput,
    input  op_e               MyOperation,
    input  csel_e             MyConstantSelect,
    output logic [DATA_W-1:0] MyOutput,
    output logic              MyStatus
);

    logic [DATA_W-1:0] k;
    logic [DATA_W-1:0] k_neg;
    logic [DATA_W-1:0] carry_in;

    assign carry_in = '0;
    assign k        = csel_to_k(MyConstantSelect);
    assign k_neg    = ~k + DATA_W'(1);

    always_comb begin
        MyOutput = MyInput;
        case (MyOperation)
            OP_ADD:  MyOutput = MyInput + k + carry_in;
            OP_SUB:  MyOutput = MyInput + k_neg + carry_in;
            OP_AND:  MyOutput = MyInput & k_neg;
            OP_OR:   MyOutput = MyInput | k_neg;
            default: MyOutput = MyInput;
        endcase
    end

    assign MyStatus = (MyOutput == '0);

endmodule

// File: rtl/comb_seq_ctrl_arb.sv
// Round-robin one-hot arbiter; the search starts at ptr and wraps.
// Purely combinational, the pointer register lives in the caller.
module comb_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == (int'(ptr) + i) % NREQ) && valid[j]) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/comb_seq_ctrl.sv
// Shares one Comb ALU among NREQ requesters: accept a command, iterate the
// ALU count times on the accumulator, then hold the result until taken.
module comb_seq_ctrl
    import comb_ctrl_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ*2-1:0]        req_op,
    input  logic [NREQ*2-1:0]        req_csel,
    input  logic [NREQ*CNT_W-1:0]    req_count,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_zero,
    output logic                     busy
);

    localparam int ID_W = $clog2(NREQ);

    state_e            state_q;
    logic [DATA_W-1:0] acc_q;
    logic              zero_q;
    op_e               op_q;
    csel_e             csel_q;
    logic [CNT_W-1:0]  rem_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_d;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   gnt_id;
    logic [DATA_W-1:0] sel_data;
    op_e               sel_op;
    csel_e             sel_csel;
    logic [CNT_W-1:0]  sel_count;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;

    comb_rr_arb #(.NREQ(NREQ)) u_arb (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    Comb u_comb (
        .MyInput          (acc_q),
        .MyOperation      (op_q),
        .MyConstantSelect (csel_q),
        .MyOutput         (alu_out),
        .MyStatus         (alu_zero)
    );

    always_comb begin
        gnt_id    = '0;
        sel_data  = '0;
        sel_op    = OP_ADD;
        sel_csel  = CSEL_1;
        sel_count = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_id    = ID_W'(i);
                sel_data  = req_data[i*DATA_W +: DATA_W];
                sel_op    = op_e'(req_op[i*2 +: 2]);
                sel_csel  = csel_e'(req_csel[i*2 +: 2]);
                sel_count = req_count[i*CNT_W +: CNT_W];
            end
        end
        ptr_d = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end

    // Gated by reset so no grant is offered while the block is held in reset.
    assign req_ready = (state_q == IDLE && !reset) ? grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            zero_q  <= 1'b0;
            op_q    <= OP_ADD;
            csel_q  <= CSEL_1;
            rem_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        acc_q  <= sel_data;
                        op_q   <= sel_op;
                        csel_q <= sel_csel;
                        rem_q  <= sel_count;
                        id_q   <= gnt_id;
                        ptr_q  <= ptr_d;
                        if (sel_count == '0) begin
                            zero_q  <= (sel_data == '0);
                            state_q <= RESP;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q  <= alu_out;
                    zero_q <= alu_zero;
                    rem_q  <= rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = acc_q;
    assign rsp_zero  = zero_q;
    assign busy      = (state_q != IDLE);

endmodule
